mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 1, memory read latency in cycles (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  run enable (switchStart); level-sensitive.
REQ-005 if_req  input  1  fetch request; if_addr  input  32  fetch word address.
REQ-006 if_ready  output  1  one-cycle fetch completion pulse; if_rdata  output  32  fetched instruction.
REQ-007 dm_req  input  1  data request; dm_we  input  1  1=store, 0=load.
REQ-008 dm_addr  input  32  data address; dm_wdata  input  32  store data.
REQ-009 dm_ready  output  1  one-cycle data completion pulse; dm_rdata  output  32  load data.
REQ-010 mem_en, mem_we  output  1 each  memory port strobes.
REQ-011 mem_addr, mem_wdata  output  32 each  memory port address and write data.
REQ-012 mem_rdata  input  32  memory read data.
REQ-013 busy  output  1  high while an access is in flight (ACCESS or RESP).

Function
REQ-014 FSM states: HALT, ARB, ACCESS, RESP.
REQ-015 HALT: all strobes low; HALT->ARB when start=1 is sampled.
REQ-016 ARB with no request: stay in ARB; ARB->HALT when start=0.
REQ-017 ARB with a request: latch grant, address, we and wdata into registers; load latency counter with MEM_LATENCY-1; go to ACCESS.
REQ-018 Only one requester pending: grant it.
REQ-019 Both requesting: round-robin on a last_grant register; data wins after reset and whenever the previous grant was fetch.
REQ-020 ACCESS: mem_en=1 with registered mem_addr, mem_we and mem_wdata held constant.
REQ-021 ACCESS decrements the counter each cycle.
REQ-022 ACCESS at counter 0: capture mem_rdata and go to RESP.
REQ-023 mem_we=1 only for a data grant with dm_we=1; fetch never writes.
REQ-024 RESP (one cycle): pulse the granted ready and drive captured data on that port's rdata; mem_en=0.
REQ-025 RESP->ARB if start=1, else RESP->HALT.
REQ-026 Latency: request sampled in ARB at cycle t; mem_en high cycles t+1..t+MEM_LATENCY; ready at t+MEM_LATENCY+1.
REQ-027 Back-to-back grants are separated by exactly one ARB cycle.
REQ-028 Stores pulse dm_ready; dm_rdata keeps its previous value.
REQ-029 if_rdata and dm_rdata hold their last value between pulses.
REQ-030 Requesters hold req, addr and wdata stable until ready.
REQ-031 A request dropped after grant still completes; the ready pulse is still issued.
REQ-032 start falling mid-access does not abort the access; return to HALT after RESP.
REQ-033 if_ready and dm_ready are never high in the same cycle.

Reset
REQ-034 rst=0 immediately forces HALT, independent of clk.
REQ-035 Reset clears all outputs, the counter and latched registers to 0, and sets last_grant=fetch so data wins first.
REQ-036 Reset during ACCESS drops mem_en in the same cycle; no ready pulse is issued for the aborted access.

Configuration
REQ-037 Macro ARB_PERF_CNT_EN.
REQ-038 With ARB_PERF_CNT_EN defined: add outputs fetch_wait_cnt and data_wait_cnt, 32 bits each.
REQ-039 Each counter increments every cycle its req=1 and that port is not in RESP.
REQ-040 Counters saturate at 32'hFFFFFFFF and reset to 0.
REQ-041 Without the macro: these ports and registers are absent; all other behaviour is identical.

Verification
REQ-042 MEM_LATENCY=1, start=1, if_req=1, if_addr=5, mem_rdata=32'hA5A5_0001 -> mem_en at t+1, if_ready with if_rdata=32'hA5A5_0001 at t+2.
REQ-043 Simultaneous if_req and dm_req (load, addr 0x40), both held -> grant order data, fetch, data; one ARB cycle between grants; no overlapping ready pulses.
REQ-044 MEM_LATENCY=3, store dm_addr=0x10, dm_wdata=0xDEAD -> mem_we high 3 cycles; dm_ready at t+4; dm_rdata unchanged.
REQ-045 Assert rst=0 mid-ACCESS -> mem_en low without waiting for a clock edge; no ready pulse; after release, HALT until start=1.
REQ-046 Drop start during ACCESS -> access completes with a ready pulse, then HALT; a new if_req is not served until start=1.
REQ-047 With ARB_PERF_CNT_EN, fetch blocked by 4 data cycles at MEM_LATENCY=1 -> fetch_wait_cnt=4 at fetch RESP.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-ported memory.
// Optional wait counters: define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] fetch_wait_cnt,
  output logic [31:0] data_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    HALT,
    ARB,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        grant_q;
  logic        last_grant;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        pick_data;
  logic        grant_fire;
  logic        done;

  // Data wins a tie unless the previous grant went to data.
  assign pick_data = dm_req & (~if_req | ~last_grant);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HALT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and port strobes.
  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    done       = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    if_ready   = 1'b0;
    dm_ready   = 1'b0;
    busy       = 1'b0;
    unique case (state)
      HALT: begin
        if (start) state_nxt = ARB;
      end
      ARB: begin
        if (!start) begin
          state_nxt = HALT;
        end else if (if_req | dm_req) begin
          grant_fire = 1'b1;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
        busy   = 1'b1;
        if (cnt == 4'd0) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        busy      = 1'b1;
        if_ready  = ~grant_q;
        dm_ready  = grant_q;
        state_nxt = start ? ARB : HALT;
      end
      default: state_nxt = HALT;
    endcase
  end

  // Grant latch, latency countdown and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      grant_q    <= 1'b0;
      last_grant <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (grant_fire) begin
        grant_q    <= pick_data;
        last_grant <= pick_data;
        we_q       <= pick_data & dm_we;
        addr_q     <= pick_data ? dm_addr : if_addr;
        wdata_q    <= pick_data ? dm_wdata : '0;
        cnt        <= CNT_INIT;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (done) begin
        if (!grant_q) if_rdata_q <= mem_rdata;
        if (grant_q && !we_q) dm_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic fetch_resp;
  logic data_resp;

  assign fetch_resp = (state == RESP) & ~grant_q;
  assign data_resp  = (state == RESP) & grant_q;

  // Saturating count of cycles each requester waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_wait_cnt <= '0;
      data_wait_cnt  <= '0;
    end else begin
      if (if_req && !fetch_resp && fetch_wait_cnt != '1)
        fetch_wait_cnt <= fetch_wait_cnt + 32'd1;
      if (dm_req && !data_resp && data_wait_cnt != '1)
        data_wait_cnt <= data_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Instance a: MEM_LATENCY=1, instance b: MEM_LATENCY=3.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] mem_rd = '0;

  logic        a_if_ready, a_dm_ready, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata;
  logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] a_fcnt, a_dcnt, b_fcnt, b_dcnt;
`endif

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .start(start1),
    .if_req(if_req), .if_addr(if_addr),
    .if_ready(a_if_ready), .if_rdata(a_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(a_dm_ready), .dm_rdata(a_dm_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rd), .busy(a_busy)
`ifdef ARB_PERF_CNT_EN
    , .fetch_wait_cnt(a_fcnt), .data_wait_cnt(a_dcnt)
`endif
  );

  mem_port_arbiter #(.MEM_LATENCY(3)) u_b (
    .clk(clk), .rst(rst), .start(start3),
    .if_req(if_req), .if_addr(if_addr),
    .if_ready(b_if_ready), .if_rdata(b_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(b_dm_ready), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rd), .busy(b_busy)
`ifdef ARB_PERF_CNT_EN
    , .fetch_wait_cnt(b_fcnt), .data_wait_cnt(b_dcnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    n_tests++;
    if ({a_mem_en, a_mem_we, a_busy, a_if_ready, a_dm_ready,
         b_mem_en, b_busy, b_if_ready, b_dm_ready} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0",
               {a_mem_en, a_mem_we, a_busy, a_if_ready, a_dm_ready,
                b_mem_en, b_busy, b_if_ready, b_dm_ready});
    end
    n_tests++;
    if ((a_mem_addr | a_mem_wdata | a_if_rdata | a_dm_rdata) !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
               a_mem_addr | a_mem_wdata | a_if_rdata | a_dm_rdata);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({a_busy, a_mem_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_idle: got %b want 00", {a_busy, a_mem_en});
    end
    start1 = 1'b1;
    tick();
  endtask

  task automatic test_fetch_latency1();
    if_req = 1'b1;
    if_addr = 32'd5;
    mem_rd = 32'hA5A5_0001;
    tick();
    n_tests++;
    if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 32'd5 ||
        a_mem_wdata !== 32'h0 || a_if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_access: en=%b we=%b addr=%h want en=1 we=0 addr=5",
               a_mem_en, a_mem_we, a_mem_addr);
    end
    tick();
    n_tests++;
    if (a_if_ready !== 1'b1 || a_if_rdata !== 32'hA5A5_0001 ||
        a_mem_en !== 1'b0 || a_dm_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_resp: rdy=%b rdata=%h en=%b want 1 a5a50001 0",
               a_if_ready, a_if_rdata, a_mem_en);
    end
    if_req = 1'b0;
    tick();
    n_tests++;
    if (a_if_ready !== 1'b0 || a_if_rdata !== 32'hA5A5_0001 ||
        a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_hold: rdy=%b rdata=%h busy=%b want 0 a5a50001 0",
               a_if_ready, a_if_rdata, a_busy);
    end
  endtask

  task automatic test_round_robin();
    logic        exp_en, exp_if, exp_dm;
    logic [31:0] exp_addr;
    if_req = 1'b1;
    if_addr = 32'h100;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h40;
    mem_rd = 32'h1111_2222;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_en = (i % 3 == 1);
      exp_dm = (i == 2 || i == 8);
      exp_if = (i == 5);
      exp_addr = (i == 4) ? 32'h100 : 32'h40;
      n_tests++;
      if (a_mem_en !== exp_en || a_if_ready !== exp_if ||
          a_dm_ready !== exp_dm ||
          (exp_en && a_mem_addr !== exp_addr)) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: en=%b if=%b dm=%b addr=%h want %b %b %b %h",
                 i, a_mem_en, a_if_ready, a_dm_ready, a_mem_addr,
                 exp_en, exp_if, exp_dm, exp_addr);
      end
      if (i == 8) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end
    tick();
    n_tests++;
    if (a_busy !== 1'b0 || a_if_rdata !== 32'h1111_2222 ||
        a_dm_rdata !== 32'h1111_2222) begin
      n_fail++;
      $display("FAIL rr_idle: busy=%b if=%h dm=%h want 0 11112222 11112222",
               a_busy, a_if_rdata, a_dm_rdata);
    end
  endtask

  task automatic test_store_latency3();
    start1 = 1'b0;
    start3 = 1'b1;
    tick();
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h20;
    mem_rd = 32'h5555_AAAA;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (i <= 3) begin
        if (b_mem_en !== 1'b1 || b_mem_we !== 1'b0 ||
            b_dm_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL load3_c%0d: en=%b we=%b rdy=%b want 1 0 0",
                   i, b_mem_en, b_mem_we, b_dm_ready);
        end
      end else begin
        if (b_dm_ready !== 1'b1 || b_mem_en !== 1'b0 ||
            b_dm_rdata !== 32'h5555_AAAA) begin
          n_fail++;
          $display("FAIL load3_resp: rdy=%b en=%b rdata=%h want 1 0 5555aaaa",
                   b_dm_ready, b_mem_en, b_dm_rdata);
        end
        dm_req = 1'b0;
      end
    end
    tick();
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_addr = 32'h10;
    dm_wdata = 32'hDEAD;
    mem_rd = 32'hFFFF_0000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (i <= 3) begin
        if (b_mem_en !== 1'b1 || b_mem_we !== 1'b1 ||
            b_mem_addr !== 32'h10 || b_mem_wdata !== 32'hDEAD ||
            b_dm_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL store3_c%0d: en=%b we=%b addr=%h wd=%h want 1 1 10 dead",
                   i, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata);
        end
      end else begin
        if (b_dm_ready !== 1'b1 || b_mem_we !== 1'b0 ||
            b_dm_rdata !== 32'h5555_AAAA) begin
          n_fail++;
          $display("FAIL store3_resp: rdy=%b we=%b rdata=%h want 1 0 5555aaaa",
                   b_dm_ready, b_mem_we, b_dm_rdata);
        end
        dm_req = 1'b0;
        dm_we = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic bad;
    if_req = 1'b1;
    if_addr = 32'd7;
    mem_rd = 32'h7777;
    tick();
    n_tests++;
    if (b_mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: en=%b want 1", b_mem_en);
    end
    tick();
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (b_mem_en !== 1'b0 || b_busy !== 1'b0 || b_if_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_async: en=%b busy=%b rdata=%h want 0 0 0",
               b_mem_en, b_busy, b_if_rdata);
    end
    start3 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b_mem_en || b_if_ready || b_busy) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_halt: activity=%b want 0", bad);
    end
    start3 = 1'b1;
    tick();
    tick();
    n_tests++;
    if (b_mem_en !== 1'b1 || b_mem_addr !== 32'd7) begin
      n_fail++;
      $display("FAIL abort_restart: en=%b addr=%h want 1 7",
               b_mem_en, b_mem_addr);
    end
    if_req = 1'b0;
    tick();
    tick();
    tick();
    n_tests++;
    if (b_if_ready !== 1'b1 || b_if_rdata !== 32'h7777) begin
      n_fail++;
      $display("FAIL dropped_req: rdy=%b rdata=%h want 1 7777",
               b_if_ready, b_if_rdata);
    end
  endtask

  task automatic test_start_drop();
    logic bad;
    tick();
    if_req = 1'b1;
    if_addr = 32'd9;
    mem_rd = 32'h9999;
    tick();
    start3 = 1'b0;
    tick();
    tick();
    tick();
    n_tests++;
    if (b_if_ready !== 1'b1 || b_if_rdata !== 32'h9999) begin
      n_fail++;
      $display("FAIL stop_resp: rdy=%b rdata=%h want 1 9999",
               b_if_ready, b_if_rdata);
    end
    if_addr = 32'hA;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b_mem_en || b_busy || b_if_ready) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_halt: activity=%b want 0", bad);
    end
    start3 = 1'b1;
    tick();
    tick();
    n_tests++;
    if (b_mem_en !== 1'b1 || b_mem_addr !== 32'hA) begin
      n_fail++;
      $display("FAIL stop_resume: en=%b addr=%h want 1 a",
               b_mem_en, b_mem_addr);
    end
    if_req = 1'b0;
    start3 = 1'b0;
    tick();
    tick();
    tick();
    n_tests++;
    if (b_if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_resume_resp: rdy=%b want 1", b_if_ready);
    end
    tick();
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b0;
    #2 rst = 1'b1;
    start1 = 1'b1;
    start3 = 1'b0;
    tick();
    n_tests++;
    if (a_fcnt !== 32'd0 || a_dcnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: f=%0d d=%0d want 0 0", a_fcnt, a_dcnt);
    end
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h40;
    tick();
    if_req = 1'b1;
    if_addr = 32'h100;
    tick();
    dm_req = 1'b0;
    tick();
    tick();
    tick();
    n_tests++;
    if (a_if_ready !== 1'b1 || a_fcnt !== 32'd4 || a_dcnt !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_count: rdy=%b f=%0d d=%0d want 1 4 2",
               a_if_ready, a_fcnt, a_dcnt);
    end
    if_req = 1'b0;
    tick();
    n_tests++;
    if (a_fcnt !== 32'd4) begin
      n_fail++;
      $display("FAIL perf_hold: f=%0d want 4", a_fcnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_latency1();
    test_round_robin();
    test_store_latency3();
    test_reset_mid_access();
    test_start_drop();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
